// File: rtl/sub_sequencer.sv
// Chunked two's-complement subtractor: diff = a - b, one BITS-wide slice per cycle,
// least-significant slice first, with N/V/C/Z flags latched on completion.
module sub_sequencer #(
  parameter int BITS  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BITS*WORDS-1:0] a,
  input  logic [BITS*WORDS-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [BITS*WORDS-1:0] diff,
  output logic                  n,
  output logic                  v,
  output logic                  co,
  output logic                  z
);

  localparam int W  = BITS * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, diff_nxt;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [BITS:0]   sum;
  logic            accept, last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        last = (idx == LAST);
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a + ~b + carry on the current slice; carry-in of slice 0 is 1
  always_comb begin
    sum = {1'b0, a_q[int'(idx)*BITS +: BITS]}
        + {1'b0, ~b_q[int'(idx)*BITS +: BITS]}
        + (BITS+1)'(carry);
    diff_nxt = diff;
    diff_nxt[int'(idx)*BITS +: BITS] = sum[BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      diff  <= '0;
      n     <= 1'b0;
      v     <= 1'b0;
      co    <= 1'b0;
      z     <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      idx   <= '0;
      carry <= 1'b1;
    end else if (state == RUN) begin
      diff  <= diff_nxt;
      carry <= sum[BITS];
      idx   <= last ? '0 : idx + 1'b1;
      // flags change only on the edge that enters DONE
      if (last) begin
        n  <= diff_nxt[W-1];
        z  <= (diff_nxt == '0);
        co <= sum[BITS];
        v  <= (a_q[W-1] != b_q[W-1]) && (diff_nxt[W-1] != a_q[W-1]);
      end
    end
  end

endmodule
